// File: rtl/mips_data_arbiter_if.sv
// Bus bundle between the CPU data port, the debug/loader port and the data RAM.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mips_data_arbiter_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   logic [ADDR_W-1:0] cpu_address;
   logic              cpu_read;
   logic              cpu_write;
   logic [DATA_W-1:0] cpu_writedata;
   logic [DATA_W-1:0] cpu_readdata;
   logic              cpu_clk_enable;

   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_address;
   logic [DATA_W-1:0] dbg_writedata;
   logic              dbg_ack;
   logic [DATA_W-1:0] dbg_readdata;

   logic [ADDR_W-1:0] mem_address;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_writedata;
   logic [DATA_W-1:0] mem_readdata;

   modport slave (
      input  cpu_address, cpu_read, cpu_write, cpu_writedata,
      output cpu_readdata, cpu_clk_enable,
      input  dbg_req, dbg_we, dbg_address, dbg_writedata,
      output dbg_ack, dbg_readdata,
      output mem_address, mem_read, mem_write, mem_writedata,
      input  mem_readdata
   );

   modport master (
      output cpu_address, cpu_read, cpu_write, cpu_writedata,
      input  cpu_readdata, cpu_clk_enable,
      output dbg_req, dbg_we, dbg_address, dbg_writedata,
      input  dbg_ack, dbg_readdata,
      input  mem_address, mem_read, mem_write, mem_writedata,
      output mem_readdata
   );
endinterface

// File: rtl/mips_data_arbiter.sv
// Shares the single data-RAM port between the CPU and a debug/loader master.
// Debug accesses steal one cycle by freezing the CPU; service is bounded by MAX_WAIT.
module mips_data_arbiter #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic                clk,
   input  logic                reset,
   mips_data_arbiter_if.slave  bus,
   output logic [15:0]         dbg_cycles
);
   localparam int unsigned       CNT_W     = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

   typedef enum logic {CPU_OWN, DBG_OWN} state_t;

   state_t            state, state_next;
   logic [CNT_W-1:0]  wait_cnt;
   logic              pending;
   logic              grant;
   logic [ADDR_W-1:0] mux_address;
   logic [DATA_W-1:0] mux_writedata;
   logic              mux_read;
   logic              mux_write;
   logic              clk_en;

   // Grant depends only on registered state and CPU strobes when gating clk_enable,
   // so dbg_req never reaches cpu_clk_enable combinationally.
   always_comb begin
      pending       = bus.dbg_req && (state == CPU_OWN) && !bus.dbg_ack;
      grant         = pending && ((!bus.cpu_read && !bus.cpu_write) || (wait_cnt == WAIT_LAST));
      state_next    = state;
      mux_address   = bus.cpu_address;
      mux_writedata = bus.cpu_writedata;
      mux_read      = bus.cpu_read;
      mux_write     = bus.cpu_write;
      clk_en        = 1'b1;
      case (state)
         CPU_OWN: begin
            if (grant) state_next = DBG_OWN;
         end
         DBG_OWN: begin
            state_next    = CPU_OWN;
            mux_address   = bus.dbg_address;
            mux_writedata = bus.dbg_writedata;
            mux_read      = !bus.dbg_we;
            mux_write     = bus.dbg_we;
            clk_en        = 1'b0;
         end
         default: state_next = CPU_OWN;
      endcase
   end

   assign bus.mem_address    = mux_address;
   assign bus.mem_writedata  = mux_writedata;
   assign bus.mem_read       = mux_read;
   assign bus.mem_write      = mux_write;
   assign bus.cpu_clk_enable = clk_en;
   assign bus.cpu_readdata   = bus.mem_readdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= CPU_OWN;
         wait_cnt         <= '0;
         bus.dbg_ack      <= 1'b0;
         bus.dbg_readdata <= '0;
         dbg_cycles       <= '0;
      end else begin
         state       <= state_next;
         bus.dbg_ack <= (state == DBG_OWN);

         if (grant)
            wait_cnt <= '0;
         else if (pending)
            wait_cnt <= wait_cnt + CNT_W'(1);

         if (state == DBG_OWN && !bus.dbg_we)
            bus.dbg_readdata <= bus.mem_readdata;

         if (state == DBG_OWN && dbg_cycles != '1)
            dbg_cycles <= dbg_cycles + 16'd1;
      end
   end
endmodule

// File: doc/mips_data_arbiter.md
# mips_data_arbiter

Two-master arbiter for the single data-RAM port of the Harvard MIPS CPU. It shares the RAM between the CPU data port and a debug/loader port, such as the bench or a host. Debug accesses are granted by freezing the CPU with `clk_enable` for one cycle. The CPU has priority, and debug is guaranteed service within `MAX_WAIT` cycles.

## Interface
- `DATA_W`, 32, data width of all data buses
- `ADDR_W`, 32, address width
- `MAX_WAIT`, 4, maximum cycles a pending debug request may be deferred while the CPU accesses memory; must be ≥1
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cpu_address`  in  ADDR_W  CPU data address
- `cpu_read`  in  1  CPU read strobe
- `cpu_write`  in  1  CPU write strobe
- `cpu_writedata`  in  DATA_W  CPU write data
- `cpu_readdata`  out  DATA_W  equals `mem_readdata`, combinational
- `cpu_clk_enable`  out  1  drives the CPU `clk_enable`; 0 freezes the CPU
- `dbg_req`  in  1  debug request; hold with address/data stable until `dbg_ack`
- `dbg_we`  in  1  1 = write, 0 = read
- `dbg_address`  in  ADDR_W  debug address
- `dbg_writedata`  in  DATA_W  debug write data
- `dbg_ack`  out  1  one-cycle completion pulse
- `dbg_readdata`  out  DATA_W  registered read data, valid while `dbg_ack`=1
- `mem_address`  out  ADDR_W  RAM address
- `mem_read`  out  1  RAM read strobe
- `mem_write`  out  1  RAM write strobe
- `mem_writedata`  out  DATA_W  RAM write data
- `mem_readdata`  in  DATA_W  combinational RAM read data
- `dbg_cycles`  out  16  saturating count of CPU-frozen cycles

## Operation
- FSM has two states: `CPU_OWN` and `DBG_OWN`.
- **`CPU_OWN` state**
  - `mem_*` outputs equal the `cpu_*` inputs.
  - `cpu_clk_enable`=1.
  - `cpu_readdata`=`mem_readdata`.
- **`DBG_OWN` state**
  - `mem_address`=`dbg_address`, `mem_writedata`=`dbg_writedata`.
  - `mem_write`=`dbg_we`, `mem_read`=!`dbg_we`.
  - `cpu_clk_enable`=0; all CPU strobes are ignored.
- **Pending request:** `dbg_req`=1 in state `CPU_OWN` with `dbg_ack`=0. Requests are ignored during an ack cycle, so the requester drops `dbg_req` there.
- **`CPU_OWN` → `DBG_OWN`** at the next edge when either condition holds:
  - a request is pending and the CPU is idle (`cpu_read`=`cpu_write`=0), or
  - a request is pending and `wait_cnt` = `MAX_WAIT`-1.
- **`wait_cnt`**, width clog2(`MAX_WAIT`+1):
  - increments each cycle a request is pending but not granted;
  - clears on grant.
- **`DBG_OWN` → `CPU_OWN`** unconditionally after one cycle. At that edge:
  - `dbg_ack`<=1;
  - `dbg_readdata`<=`mem_readdata` on a read; unchanged on a write.
- `dbg_ack` is high for exactly one cycle; it clears at the next edge.
- `dbg_cycles` increments once per `DBG_OWN` cycle and saturates at 16'hFFFF.
- A CPU access issued in the cycle before a grant completes normally: `clk_enable`=1 that cycle, so its write commits at that edge.

## Timing
- **Reset** (`reset`=0, asynchronous): state=`CPU_OWN`, `wait_cnt`=0, `dbg_ack`=0, `dbg_readdata`=0, `dbg_cycles`=0.
  - Hence `cpu_clk_enable`=1 and `mem_*` follow the CPU during reset.
- Deassertion is sampled at the first rising edge with `reset`=1.
- **Debug latency, CPU idle:**
  - request seen in cycle N;
  - `DBG_OWN` in cycle N+1 (RAM write commits at the end of N+1);
  - `dbg_ack` in N+2.
- **Debug latency, CPU busy:** worst case `DBG_OWN` at N+`MAX_WAIT`, ack at N+`MAX_WAIT`+1.
- **Back-to-back debug:** new `dbg_req` may be raised the cycle after ack. The CPU therefore gets at least 2 enabled cycles between frozen cycles (the ack cycle plus at least one more).
- **Reset mid-transaction:**
  - a `DBG_OWN` cycle aborts;
  - no ack is produced;
  - the RAM write has not committed unless the rising edge preceded reset assertion.
- `cpu_readdata` in `DBG_OWN` reflects debug data. It is harmless because the CPU is frozen.
- All outputs except `dbg_ack`, `dbg_readdata` and `dbg_cycles` are combinational from state and inputs. There is no combinational path from `dbg_req` to `cpu_clk_enable`.

## Test plan
- **Reset:** assert `reset`=0 with `dbg_req`=1 → `cpu_clk_enable`=1, `dbg_ack`=0, `dbg_cycles`=0. After release, `mem_address` mirrors `cpu_address`=32'h10.
- **Idle-CPU write:** CPU strobes 0; debug write addr 32'h04 data 32'hDEADBEEF.
  - `cpu_clk_enable`=0 for exactly one cycle;
  - `ram[1]`=DEADBEEF;
  - `dbg_ack` pulses 2 cycles after the request;
  - `dbg_cycles`=1.
- **Readback:** debug read addr 32'h04 → `dbg_readdata`=32'hDEADBEEF while `dbg_ack`=1.
- **Starvation bound:** `MAX_WAIT`=4, `cpu_read`=1 continuously, `dbg_req` raised at cycle N → `cpu_clk_enable`=0 in exactly cycle N+4; ack at N+5.
- **Collision:** CPU writes 32'h11111111 to 32'h08 in the cycle before the grant; debug then writes 32'h22222222 to 32'h08 → final `ram[2]`=32'h22222222.
- **Abort and saturation:**
  - assert reset during `DBG_OWN` → no `dbg_ack`, `dbg_cycles` returns to 0;
  - separately, force 65536 or more frozen cycles → `dbg_cycles` holds 16'hFFFF.
